// File: rtl/spi_master_shift_engine_if.sv
// ----------------------------------------------------------------------------
// spi_master_shift_engine_if
// Bundles everything the SPI shift engine exchanges with the outside world:
//   - word handshake    : tx_data/tx_valid/tx_ready, rx_data/rx_valid, busy
//   - transfer config   : cpol, cpha, lsb_first, clk_div, ss_sel
//   - SPI master pins   : sig_mi (in), sig_sclk_out, sig_n_sclk_en, sig_mo,
//                         sig_n_mo_en, sig_n_ss_out[3:0], sig_n_ss_en (out)
// Modports:
//   slave  - the engine's view (consumes words/config, drives the pins)
//   master - the register front-end / pad side view
// ----------------------------------------------------------------------------
interface spi_master_shift_engine_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic [1:0]        ss_sel;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              sig_mi;
    logic              sig_sclk_out;
    logic              sig_n_sclk_en;
    logic              sig_mo;
    logic              sig_n_mo_en;
    logic [3:0]        sig_n_ss_out;
    logic              sig_n_ss_en;

    modport slave (
        input  tx_data, tx_valid, cpol, cpha, lsb_first, clk_div, ss_sel, sig_mi,
        output tx_ready, rx_data, rx_valid, busy,
               sig_sclk_out, sig_n_sclk_en, sig_mo, sig_n_mo_en, sig_n_ss_out, sig_n_ss_en
    );

    modport master (
        output tx_data, tx_valid, cpol, cpha, lsb_first, clk_div, ss_sel, sig_mi,
        input  tx_ready, rx_data, rx_valid, busy,
               sig_sclk_out, sig_n_sclk_en, sig_mo, sig_n_mo_en, sig_n_ss_out, sig_n_ss_en
    );
endinterface

// File: rtl/spi_master_shift_engine.sv
// ----------------------------------------------------------------------------
// spi_master_shift_engine
// SPI master serialiser/deserialiser. Accepts one parallel word, generates a
// divided SCLK (CPOL/CPHA), drives one active-low slave select, shifts the word
// out on MOSI while capturing a word from MISO, then returns the received word
// with a one-cycle rx_valid pulse.
//
// Ports:
//   pclk       - system clock, everything on the rising edge
//   n_p_reset  - synchronous active-low reset
//   bus        - spi_master_shift_engine_if.slave (handshake, config, pins)
//
// Timing with H = clk_div+1, accept in cycle N:
//   SETUP  N+1 .. N+H                 SS/enables asserted, first bit on MOSI
//   SHIFT  2*DATA_W slots of H cycles, SCLK toggles at the end of each slot
//   HOLD   H cycles at SCLK idle level
//   IDLE   reached in N+1+H*(2*DATA_W+2) together with rx_valid
// ----------------------------------------------------------------------------
module spi_master_shift_engine #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic                        pclk,
    input  logic                        n_p_reset,
    spi_master_shift_engine_if.slave    bus
);

    localparam int                EDGE_W    = $clog2(2*DATA_W+1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W);
    localparam logic [EDGE_W-1:0] FIRST_EDGE = EDGE_W'(1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   cnt_q;      // counts H-1 .. 0 within each slot
    logic [DIV_W-1:0]   div_q;
    logic [EDGE_W-1:0]  edge_q;     // SCLK toggles issued so far
    logic               cpol_q;
    logic               cpha_q;
    logic               lsb_q;
    logic [DATA_W-1:0]  tx_sr_q;    // bits still to be sent (current bit already on mo)
    logic [DATA_W-1:0]  rx_sr_q;

    logic               tx_ready_q;
    logic [DATA_W-1:0]  rx_data_q;
    logic               rx_valid_q;
    logic               busy_q;
    logic               sclk_q;
    logic               n_sclk_en_q;
    logic               mo_q;
    logic               n_mo_en_q;
    logic [3:0]         n_ss_out_q;
    logic               n_ss_en_q;

    logic [EDGE_W-1:0]  edge_d;
    logic               tx_bit_d;
    logic [DATA_W-1:0]  tx_sr_d;
    logic [DATA_W-1:0]  rx_sr_d;
    logic               sample_d;
    logic               advance_d;
    logic               first_bit_d;
    logic [DATA_W-1:0]  load_sr_d;
    logic [3:0]         ss_dec_d;

    always_comb begin
        edge_d      = edge_q + 1'b1;
        tx_bit_d    = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
        tx_sr_d     = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
        rx_sr_d     = lsb_q ? {bus.sig_mi, rx_sr_q[DATA_W-1:1]}
                            : {rx_sr_q[DATA_W-2:0], bus.sig_mi};
        // Odd toggle numbers are leading edges. cpha picks which edge samples;
        // the other edge advances MOSI, except where that would run past the
        // word (first leading edge for cpha=1, last trailing edge for cpha=0).
        sample_d    = edge_d[0] ? !cpha_q : cpha_q;
        advance_d   = edge_d[0] ? (cpha_q && (edge_d != FIRST_EDGE))
                                : (!cpha_q && (edge_d != LAST_EDGE));
        first_bit_d = bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
        load_sr_d   = bus.lsb_first ? (bus.tx_data >> 1) : (bus.tx_data << 1);
        ss_dec_d    = ~(4'b0001 << bus.ss_sel);
    end

    always_ff @(posedge pclk) begin
        if (!n_p_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            edge_q      <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            tx_ready_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            sclk_q      <= 1'b0;
            n_sclk_en_q <= 1'b1;
            mo_q        <= 1'b0;
            n_mo_en_q   <= 1'b1;
            n_ss_out_q  <= 4'hF;
            n_ss_en_q   <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_ready_q <= 1'b1;
                    sclk_q     <= bus.cpol;     // idle level tracks live cpol
                    if (bus.tx_valid && tx_ready_q) begin
                        state_q     <= SETUP;
                        tx_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= bus.clk_div;
                        div_q       <= bus.clk_div;
                        edge_q      <= '0;
                        cpol_q      <= bus.cpol;
                        cpha_q      <= bus.cpha;
                        lsb_q       <= bus.lsb_first;
                        tx_sr_q     <= load_sr_d;
                        rx_sr_q     <= '0;
                        mo_q        <= first_bit_d;
                        n_ss_out_q  <= ss_dec_d;
                        n_ss_en_q   <= 1'b0;
                        n_sclk_en_q <= 1'b0;
                        n_mo_en_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= SHIFT;
                        cnt_q   <= div_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        cnt_q  <= div_q;
                        edge_q <= edge_d;
                        sclk_q <= ~sclk_q;
                        if (sample_d) begin
                            rx_sr_q <= rx_sr_d;
                        end
                        if (advance_d) begin
                            mo_q    <= tx_bit_d;
                            tx_sr_q <= tx_sr_d;
                        end
                        if (edge_d == LAST_EDGE) begin
                            state_q <= HOLD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    sclk_q <= cpol_q;
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        rx_valid_q  <= 1'b1;
                        rx_data_q   <= rx_sr_q;
                        tx_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        sclk_q      <= bus.cpol;
                        n_ss_out_q  <= 4'hF;
                        n_ss_en_q   <= 1'b1;
                        n_sclk_en_q <= 1'b1;
                        n_mo_en_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready      = tx_ready_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.busy          = busy_q;
    assign bus.sig_sclk_out  = sclk_q;
    assign bus.sig_n_sclk_en = n_sclk_en_q;
    assign bus.sig_mo        = mo_q;
    assign bus.sig_n_mo_en   = n_mo_en_q;
    assign bus.sig_n_ss_out  = n_ss_out_q;
    assign bus.sig_n_ss_en   = n_ss_en_q;

endmodule

// File: tb/tb_spi_master_shift_engine.sv
// ----------------------------------------------------------------------------
// tb_spi_master_shift_engine
// Directed vectors; expected rx words and their arrival cycles are queued when
// a word is accepted and checked by an independent rx monitor.
// ----------------------------------------------------------------------------
module tb_spi_master_shift_engine;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;
    localparam int NTOG   = 2*DATA_W;
    localparam int BUDGET = 10000;

    logic pclk = 1'b0;
    logic n_p_reset = 1'b0;
    always #5 pclk = ~pclk;

    spi_master_shift_engine_if #(.DATA_W(DATA_W), .DIV_W(DIV_W)) bus();

    spi_master_shift_engine #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .pclk      (pclk),
        .n_p_reset (n_p_reset),
        .bus       (bus)
    );

    logic loop_en = 1'b0;
    logic mi_tie  = 1'b0;
    assign bus.sig_mi = loop_en ? bus.sig_mo : mi_tie;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // rx monitor: every rx_valid must match the oldest queued expectation
    always @(negedge pclk) begin
        if (bus.rx_valid === 1'b1) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL rx_unexpected: rx_valid with rx_data 0x%0h, none expected (cycle %0d)",
                         bus.rx_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rx_data", 32'(bus.rx_data), 32'(e.data));
                chk("rx_cycle", cyc, e.due);
            end
        end
    end

    // Present a word; called and returns at a negedge.
    task automatic send(input logic [7:0] d, input logic [7:0] exp, input bit push,
                        input bit keep, output int acc);
        exp_t e;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        acc = -1;
        for (int t = 0; t < BUDGET && bus.tx_ready !== 1'b1; t++) @(negedge pclk);
        if (bus.tx_ready !== 1'b1) begin
            nchk++;
            nerr++;
            $display("FAIL accept_timeout: tx_ready=%b, required 1", bus.tx_ready);
            bus.tx_valid = 1'b0;
            return;
        end
        acc = cyc;
        if (push) begin
            e.data = exp;
            e.due  = cyc + 1 + (int'(bus.clk_div) + 1) * (NTOG + 2);
            sb.push_back(e);
        end
        @(negedge pclk);
        if (!keep) bus.tx_valid = 1'b0;
    endtask

    task automatic wait_rx();
        for (int t = 0; t < BUDGET && bus.rx_valid !== 1'b1; t++) @(negedge pclk);
        if (bus.rx_valid !== 1'b1) begin
            nchk++;
            nerr++;
            $display("FAIL rx_timeout: rx_valid=%b, required 1", bus.rx_valid);
        end
    endtask

    // Follow a transfer until rx_valid: count toggles, capture mo at each
    // sampling edge (index = bit order on the wire), check SS/enables.
    task automatic watch(input logic [3:0] exp_ss, output int tog,
                         output logic [7:0] seq, output bit pins_ok);
        logic prev;
        bit   seen;
        int   idx;
        tog = 0;
        seq = '0;
        seen = 1'b0;
        prev = bus.sig_sclk_out;
        pins_ok = (bus.sig_n_ss_out === exp_ss) && (bus.sig_n_ss_en === 1'b0) &&
                  (bus.sig_n_sclk_en === 1'b0) && (bus.sig_n_mo_en === 1'b0);
        for (int t = 0; t < BUDGET; t++) begin
            @(negedge pclk);
            if (bus.rx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if ((bus.sig_n_ss_out !== exp_ss) || (bus.sig_n_ss_en !== 1'b0) ||
                (bus.sig_n_sclk_en !== 1'b0) || (bus.sig_n_mo_en !== 1'b0))
                pins_ok = 1'b0;
            if (bus.sig_sclk_out !== prev) begin
                tog++;
                prev = bus.sig_sclk_out;
                if ((tog % 2 == 1) != bus.cpha) begin
                    idx = (tog - 1) / 2;
                    if (idx < 8) seq[idx] = bus.sig_mo;
                end
            end
        end
        if (!seen) begin
            nchk++;
            nerr++;
            $display("FAIL watch_timeout: no rx_valid after %0d toggles", tog);
        end
    endtask

    initial begin
        int acc, acc2, tog;
        logic [7:0] seq;
        bit ok;

        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.cpol      = 1'b1;
        bus.cpha      = 1'b0;
        bus.lsb_first = 1'b0;
        bus.clk_div   = '0;
        bus.ss_sel    = '0;

        // Reset state
        n_p_reset = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_tx_ready", bus.tx_ready, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sclk", bus.sig_sclk_out, 0);
        chk("rst_mo", bus.sig_mo, 0);
        chk("rst_enables", {bus.sig_n_sclk_en, bus.sig_n_mo_en, bus.sig_n_ss_en}, 3'b111);
        chk("rst_ss", bus.sig_n_ss_out, 4'hF);
        n_p_reset = 1'b1;
        @(negedge pclk);
        chk("post_rst_tx_ready", bus.tx_ready, 1);
        chk("post_rst_sclk_cpol", bus.sig_sclk_out, 1);
        bus.cpol = 1'b0;
        @(negedge pclk);

        // 1: mode 0, MSB first, H=2, ss 0, loopback 0xA5
        bus.clk_div = 8'd1;
        loop_en = 1'b1;
        send(8'hA5, 8'hA5, 1'b1, 1'b0, acc);
        watch(4'b1110, tog, seq, ok);
        chk("t1_toggles", tog, NTOG);
        chk("t1_mo_seq", seq, 8'hA5);
        chk("t1_pins", ok, 1);
        chk("t1_ss_release", bus.sig_n_ss_out, 4'hF);
        chk("t1_en_release", {bus.sig_n_sclk_en, bus.sig_n_mo_en, bus.sig_n_ss_en}, 3'b111);
        chk("t1_busy_clear", bus.busy, 0);
        @(negedge pclk);

        // 2: cpol=1 cpha=1 LSB first, H=3, ss 3, mi tied 1
        bus.cpol = 1'b1;
        bus.cpha = 1'b1;
        bus.lsb_first = 1'b1;
        bus.ss_sel = 2'd3;
        bus.clk_div = 8'd2;
        loop_en = 1'b0;
        mi_tie = 1'b1;
        @(negedge pclk);
        chk("t2_sclk_idle", bus.sig_sclk_out, 1);
        send(8'h3C, 8'hFF, 1'b1, 1'b0, acc);
        watch(4'b0111, tog, seq, ok);
        chk("t2_toggles", tog, NTOG);
        chk("t2_mo_seq", seq, 8'h3C);
        chk("t2_pins", ok, 1);
        chk("t2_sclk_end", bus.sig_sclk_out, 1);
        @(negedge pclk);

        // 3: H=1, back-to-back with tx_valid held high
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.lsb_first = 1'b0;
        bus.ss_sel = 2'd1;
        bus.clk_div = 8'd0;
        loop_en = 1'b1;
        @(negedge pclk);
        send(8'h01, 8'h01, 1'b1, 1'b1, acc);
        send(8'h80, 8'h80, 1'b1, 1'b0, acc2);
        chk("t3_spacing", acc2 - acc, 19);
        wait_rx();
        @(negedge pclk);

        // 4: tx_valid pulse and cpol flip mid-SHIFT are ignored
        send(8'h5A, 8'h5A, 1'b1, 1'b0, acc);
        repeat (5) @(negedge pclk);
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        bus.cpol = 1'b1;
        chk("t4_tx_ready_busy", bus.tx_ready, 0);
        chk("t4_busy", bus.busy, 1);
        @(negedge pclk);
        chk("t4_tx_ready_busy2", bus.tx_ready, 0);
        bus.tx_valid = 1'b0;
        wait_rx();
        repeat (40) @(negedge pclk);
        chk("t4_idle_new_cpol", bus.sig_sclk_out, 1);
        chk("t4_no_restart", bus.busy, 0);
        bus.cpol = 1'b0;
        @(negedge pclk);

        // 6: maximum divider (H=256), cpha=1, ss 2
        bus.clk_div = 8'hFF;
        bus.cpha = 1'b1;
        bus.ss_sel = 2'd2;
        send(8'hC3, 8'hC3, 1'b1, 1'b0, acc);
        watch(4'b1011, tog, seq, ok);
        chk("t6_toggles", tog, NTOG);
        chk("t6_mo_seq", seq, 8'hC3);
        chk("t6_pins", ok, 1);
        @(negedge pclk);

        // 5: reset on the 5th sclk toggle
        bus.clk_div = 8'd1;
        bus.cpha = 1'b0;
        bus.ss_sel = 2'd0;
        send(8'h96, 8'h00, 1'b0, 1'b0, acc);
        begin
            logic prev;
            int   n;
            n = 0;
            prev = bus.sig_sclk_out;
            for (int t = 0; t < BUDGET && n < 5; t++) begin
                @(negedge pclk);
                if (bus.sig_sclk_out !== prev) begin
                    n++;
                    prev = bus.sig_sclk_out;
                end
            end
            chk("t5_reached_5_toggles", n, 5);
        end
        n_p_reset = 1'b0;
        @(negedge pclk);
        chk("t5_ss", bus.sig_n_ss_out, 4'hF);
        chk("t5_enables", {bus.sig_n_sclk_en, bus.sig_n_mo_en, bus.sig_n_ss_en}, 3'b111);
        chk("t5_busy", bus.busy, 0);
        chk("t5_rx_valid", bus.rx_valid, 0);
        chk("t5_rx_data", bus.rx_data, 0);
        n_p_reset = 1'b1;
        @(negedge pclk);
        chk("t5_tx_ready", bus.tx_ready, 1);
        repeat (60) @(negedge pclk);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
